// File: rtl/trig_burst_pkg.sv
// Shared types and helpers for the trigger-driven burst generator.
package trig_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a bit-select into a WIDTH-wide trigger bus, never below 1.
    function automatic int sel_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that times the high phase of one output pulse.
// After a load of value L the counter is nonzero for exactly L cycles and
// 'last' marks the final one of them.
module pulse_timer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    output logic             active,
    output logic             last
);

    logic [LEN_W-1:0] cnt;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    assign active = (cnt != '0);
    assign last   = (cnt == LEN_W'(1));

endmodule

// File: rtl/trig_burst_gen.sv
// Burst pulse generator: on start, emits n_pulses pulses of pulse_len cycles,
// each launched by one event on the selected trigger bit.
// Handshake: start is a level request that is only taken when the block is
// idle (busy=0) and abort is low; done is a one-cycle completion strobe.
module trig_burst_gen
    import trig_burst_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         trig_in,
    input  logic [sel_w(WIDTH)-1:0]  sel,
    input  logic [CNT_W-1:0]         n_pulses,
    input  logic [LEN_W-1:0]         pulse_len,
    input  logic                     start,
    input  logic                     abort,
    output logic                     pulse_out,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [CNT_W-1:0]         remaining
);

    localparam int SEL_W = sel_w(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] sel_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] rem_q;
    logic             pulse_q;
    logic             ovr_q;

    logic             trig_hit;
    logic             accept;
    logic             tmr_load;
    logic             tmr_active;
    logic             tmr_last;
    logic             pulse_end;

    assign trig_hit  = trig_in[sel_q];
    assign accept    = (state == IDLE) && start && !abort;
    assign tmr_load  = (state == ARMED) && trig_hit && !abort;
    // A zero counter in PULSE cannot happen with a clamped length; treat it
    // as the last cycle so the FSM can never stall there.
    assign pulse_end = (state == PULSE) && (tmr_last || !tmr_active);

    pulse_timer #(.LEN_W(LEN_W)) u_width (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort),
        .load     (tmr_load),
        .load_val (len_q),
        .active   (tmr_active),
        .last     (tmr_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort returns to IDLE from any busy state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (n_pulses == '0) ? DONE : ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (trig_hit) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pulse_end) begin
                    state_next = (rem_q == CNT_W'(1)) ? DONE : ARMED;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (state != IDLE) begin
            busy = 1'b1;
        end
        if (state == DONE) begin
            done = 1'b1;
        end
    end

    // Burst parameters captured once per accepted non-empty start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            len_q <= '0;
        end else if (accept && (n_pulses != '0)) begin
            sel_q <= sel;
            len_q <= (pulse_len == '0) ? LEN_W'(1) : pulse_len;
        end
    end

    // Pulses left to emit, counted down as each pulse finishes.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem_q <= '0;
        end else if (accept) begin
            rem_q <= n_pulses;
        end else if (pulse_end) begin
            rem_q <= rem_q - CNT_W'(1);
        end
    end

    // Sticky overrun: a selected trigger landed while a pulse was still high.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ovr_q <= 1'b0;
        end else if ((state == PULSE) && trig_hit && !abort) begin
            ovr_q <= 1'b1;
        end
    end

    // Registered pulse output, high for every cycle spent in PULSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= (state_next == PULSE);
        end
    end

    assign pulse_out = pulse_q;
    assign overrun   = ovr_q;
    assign remaining = rem_q;

endmodule

// File: doc/trig_burst_gen.md
Name: trig_burst_gen

Overview:
- Consumer of the free-running counter's `trig_out` bus.
- Selects one trigger bit as a time base (bit k fires once every 2^(k+1) enabled counts).
- On `start`, emits a burst of N output pulses of programmable width, one per selected trigger event.
- Used as the pulse/strobe generator that drives downstream peripherals from the shared timebase.

Parameters:
- WIDTH, 8, width of `trig_in`; must equal the upstream counter WIDTH.
- CNT_W, 8, width of the burst pulse-count field.
- LEN_W, 8, width of the pulse-length field, in clk cycles.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- trig_in  in  WIDTH  single-cycle trigger pulses from the counter's `trig_out`.
- sel  in  $clog2(WIDTH)  trigger bit select; sampled at an accepted start.
- n_pulses  in  CNT_W  number of pulses in the burst; sampled at an accepted start.
- pulse_len  in  LEN_W  high time of each pulse, in cycles; sampled at an accepted start; 0 is treated as 1.
- start  in  1  request a burst; honoured only in IDLE.
- abort  in  1  synchronous cancel of the current burst.
- pulse_out  out  1  registered burst output.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse marking normal burst completion.
- overrun  out  1  sticky flag: a selected trigger arrived while in PULSE; cleared by an accepted start or by rst.
- remaining  out  CNT_W  pulses still to emit, including the one currently in progress.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE.
  - pulse_out, busy, done, overrun = 0; remaining = 0.
  - Latched sel/len/count registers = 0.
  - Reset has priority over every other input, including during a burst.
- States: IDLE, ARMED, PULSE, DONE (2-bit enum).
- IDLE:
  - start=1 with n_pulses≠0: latch sel, n_pulses and max(pulse_len,1); clear overrun; go to ARMED. busy=1 from the next cycle.
  - start=1 with n_pulses=0: go to DONE directly; no pulses are emitted.
- ARMED:
  - If trig_in[sel_q]=1 at edge t: go to PULSE.
  - pulse_out=1 for cycles t+1 .. t+len_q (exactly len_q cycles).
  - Other trig_in bits are ignored.
- PULSE:
  - An internal width counter runs down to 0.
  - On the last high cycle: decrement remaining.
    - If the new remaining is 0, go to DONE.
    - Otherwise go to ARMED; pulse_out is 0 on the following cycle.
  - If trig_in[sel_q]=1 during PULSE: set overrun. That trigger is lost, not queued.
- Trigger coinciding with the exit edge:
  - A selected trigger on the same edge that PULSE→ARMED is not seen by ARMED; it counts as overrun.
  - Consequence: pulse_len ≥ the trigger period guarantees missed events.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE.
- start outside IDLE: ignored; it does not relatch fields or clear overrun.
- abort=1 in ARMED, PULSE or DONE:
  - Next cycle: IDLE, pulse_out=0, remaining=0, done=0.
  - overrun is preserved.
- abort and start together in IDLE: abort wins; the start is dropped.
- Input changes: sel, n_pulses and pulse_len may change freely mid-burst without effect.
- Width rules:
  - remaining holds at 2^CNT_W−1 maximum.
  - len counter is LEN_W bits; pulse_len=2^LEN_W−1 is legal.
  - No wrap-around occurs in either counter.

Decomposition:
- Package `trig_burst_pkg`:
  - state_t enum {IDLE, ARMED, PULSE, DONE}.
  - Function sel_w(WIDTH) returning $clog2(WIDTH), minimum 1.
- Sub-module `pulse_timer`:
  - Loadable LEN_W down-counter with load, active and last outputs.
  - Instantiated once for the pulse width.
  - FSM, remaining counter and overrun logic stay in the top module.

Test Plan:
- Basic burst: WIDTH=8, sel=0, trig_in[0] pulsed every 2 cycles, n_pulses=3, pulse_len=1 → three 1-cycle pulses each one cycle after a trigger; remaining 3→2→1→0; done high once; busy low the cycle after done.
- Width clamp and overrun: sel=2 (period 8), pulse_len=0 → pulses of width 1. Repeat with pulse_len=10 → overrun=1 after the first pulse, only every other trigger honoured, n_pulses=2 still ends with done.
- Zero count: start with n_pulses=0 → done one cycle later, pulse_out never high, busy high for exactly one cycle.
- Abort mid-pulse: n_pulses=4, pulse_len=5, assert abort in the 3rd high cycle of pulse 2 → pulse_out low next cycle, remaining=0, no done, state IDLE; a subsequent start succeeds.
- Reset mid-burst and ignored start: rst during ARMED → all outputs 0 next cycle. Separately, start with new fields during PULSE → burst continues with the original count/len; overrun not cleared.
- End-to-end: instantiate with the WIDTH=4 counter, sel=3, n_pulses=2 → pulses begin at counter wrap (count 15→0) on two consecutive wraps, 16 cycles apart.
